// File: rtl/adc_pkg.sv
// Shared defaults for the I2S ADC receiver: word width, bit-clock divider and slot layout.
package adc_pkg;
  localparam int ADC_SAMPLE_BITS = 24;
  localparam int ADC_BCLK_DIV    = 8;
  localparam int ADC_SLOT_BITS   = 32;
  localparam int FRAME_SLOTS     = 2 * ADC_SLOT_BITS;
  localparam int SLOT_CNT_W      = $clog2(FRAME_SLOTS);
endpackage

// File: rtl/adc_clk_gen.sv
// Derives adc_bclk/adc_lrck from mclk and marks the mclk cycle that ends each bclk high phase.
// The strobe cycle carries the slot number being captured; bclk and lrck fall together on its edge.
module adc_clk_gen
  import adc_pkg::*;
#(
  parameter int BCLK_DIV = ADC_BCLK_DIV
) (
  input  logic                  mclk,
  input  logic                  rst,
  output logic [SLOT_CNT_W-1:0] o_slot_cnt,
  output logic                  o_bclk,
  output logic                  o_lrck,
  output logic                  o_sample_stb
);
  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);

  logic [DIV_W-1:0]      r_div_cnt;
  logic [DIV_W-1:0]      w_div_nxt;
  logic [SLOT_CNT_W-1:0] r_slot_cnt;
  logic [SLOT_CNT_W-1:0] w_slot_nxt;
  logic                  w_wrap;
  logic                  r_bclk;
  logic                  r_lrck;

  assign w_wrap     = (r_div_cnt == DIV_LAST);
  assign w_div_nxt  = w_wrap ? '0 : r_div_cnt + DIV_W'(1);
  assign w_slot_nxt = w_wrap ? r_slot_cnt + SLOT_CNT_W'(1) : r_slot_cnt;

  // bclk/lrck are registered from the next-state counters so they track the counters exactly.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_slot_cnt <= '0;
      r_bclk     <= 1'b0;
      r_lrck     <= 1'b0;
    end else begin
      r_div_cnt  <= w_div_nxt;
      r_slot_cnt <= w_slot_nxt;
      r_bclk     <= (w_div_nxt >= DIV_HALF);
      r_lrck     <= w_slot_nxt[SLOT_CNT_W-1];
    end
  end

  assign o_slot_cnt   = r_slot_cnt;
  assign o_bclk       = r_bclk;
  assign o_lrck       = r_lrck;
  assign o_sample_stb = w_wrap;
endmodule

// File: rtl/adc_i2s_rx.sv
// I2S ADC receiver: deserialises left/right words and presents them as a valid/ready pair.
// sample_valid rises 1 mclk after the last right bit; a pair completing while one is still held is dropped and flagged on overrun.
module adc_i2s_rx
  import adc_pkg::*;
#(
  parameter int SAMPLE_BITS = ADC_SAMPLE_BITS,
  parameter int BCLK_DIV    = ADC_BCLK_DIV,
  parameter int SLOT_BITS   = ADC_SLOT_BITS
) (
  input  logic                   mclk,
  input  logic                   rst,
  output logic                   adc_bclk,
  output logic                   adc_lrck,
  input  logic                   adc_sdata,
  output logic [SAMPLE_BITS-1:0] sample_l,
  output logic [SAMPLE_BITS-1:0] sample_r,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun
);
  // One-slot I2S delay: data occupies slots 1..N of each half frame.
  localparam logic [SLOT_CNT_W-1:0] L_FIRST = SLOT_CNT_W'(1);
  localparam logic [SLOT_CNT_W-1:0] L_LAST  = SLOT_CNT_W'(SAMPLE_BITS);
  localparam logic [SLOT_CNT_W-1:0] R_FIRST = SLOT_CNT_W'(SLOT_BITS + 1);
  localparam logic [SLOT_CNT_W-1:0] R_LAST  = SLOT_CNT_W'(SLOT_BITS + SAMPLE_BITS);

  logic [SLOT_CNT_W-1:0]  w_slot_cnt;
  logic                   w_stb;
  logic                   w_in_word;
  logic                   w_pair_done;
  logic                   w_load;
  logic [SAMPLE_BITS-1:0] w_shift_nxt;
  logic [SAMPLE_BITS-2:0] r_shift;
  logic [SAMPLE_BITS-1:0] r_left;
  logic [SAMPLE_BITS-1:0] r_sample_l;
  logic [SAMPLE_BITS-1:0] r_sample_r;
  logic                   r_valid;
  logic                   r_overrun;

  adc_clk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .mclk         (mclk),
    .rst          (rst),
    .o_slot_cnt   (w_slot_cnt),
    .o_bclk       (adc_bclk),
    .o_lrck       (adc_lrck),
    .o_sample_stb (w_stb)
  );

  assign w_in_word   = ((w_slot_cnt >= L_FIRST) && (w_slot_cnt <= L_LAST)) ||
                       ((w_slot_cnt >= R_FIRST) && (w_slot_cnt <= R_LAST));
  assign w_shift_nxt = {r_shift, adc_sdata};
  assign w_pair_done = w_stb && (w_slot_cnt == R_LAST);
  assign w_load      = w_pair_done && (!r_valid || sample_ready);

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_left     <= '0;
      r_sample_l <= '0;
      r_sample_r <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_stb && w_in_word) r_shift <= w_shift_nxt[SAMPLE_BITS-2:0];
      if (w_stb && (w_slot_cnt == L_LAST)) r_left <= w_shift_nxt;
      r_overrun <= w_pair_done && r_valid && !sample_ready;
      // A completion in the same cycle as a consume replaces the pair, so valid stays high.
      if (w_load) begin
        r_sample_l <= r_left;
        r_sample_r <= w_shift_nxt;
        r_valid    <= 1'b1;
      end else if (r_valid && sample_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign sample_l     = r_sample_l;
  assign sample_r     = r_sample_r;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;
endmodule

// File: tb/tb_adc_i2s_rx.sv
// Bench for adc_i2s_rx: a behavioural ADC drives frames by mclk edge count, a pair-level model predicts outputs.
module tb_adc_i2s_rx;
  localparam int SB          = 24;
  localparam int DIV         = 8;
  localparam int SLB         = 32;
  localparam int FR          = 2 * SLB;
  localparam int DONE_SLOT   = SLB + SB;
  localparam int FIRST_VALID = (DONE_SLOT + 1) * DIV;
  localparam int PAIR_MCLK   = FR * DIV;

  logic          mclk;
  logic          rst;
  logic          adc_sdata;
  logic          sample_ready;
  logic          adc_bclk;
  logic          adc_lrck;
  logic          sample_valid;
  logic          overrun;
  logic [SB-1:0] sample_l;
  logic [SB-1:0] sample_r;

  adc_i2s_rx dut (
    .mclk         (mclk),
    .rst          (rst),
    .adc_bclk     (adc_bclk),
    .adc_lrck     (adc_lrck),
    .adc_sdata    (adc_sdata),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int            n;
  int            passed;
  int            total;
  logic          mv;
  logic          mo;
  logic [SB-1:0] ml;
  logic [SB-1:0] mr;
  logic [SB-1:0] fl [8];
  logic [SB-1:0] fr [8];

  wire [2*SB+3:0] got_vec = {adc_bclk, adc_lrck, sample_valid, overrun, sample_l, sample_r};

  function automatic logic [2*SB+3:0] exp_vec();
    logic eb;
    logic el;
    eb = (n % DIV) >= (DIV / 2);
    el = ((n / DIV) % FR) >= SLB;
    return {eb, el, mv, mo, ml, mr};
  endfunction

  // Bit the ADC presents during the slot containing the next mclk edge; unused slots carry noise.
  function automatic logic adc_bit(int edges);
    int g;
    int f;
    int s;
    g = edges / DIV;
    f = g / FR;
    s = g % FR;
    if (f > 7) f = 7;
    if (s >= 1 && s <= SB) return fl[f][SB-s];
    if (s > SLB && s <= SLB + SB) return fr[f][SLB+SB-s];
    return 1'($urandom);
  endfunction

  task automatic random_words();
    for (int i = 0; i < 8; i++) begin
      fl[i] = SB'($urandom);
      fr[i] = SB'($urandom);
    end
  endtask

  task automatic step();
    int   e;
    int   f;
    logic done;
    @(negedge mclk);
    adc_sdata = adc_bit(n);
    @(posedge mclk);
    e    = n + 1;
    done = (e % DIV == 0) && (((e / DIV - 1) % FR) == DONE_SLOT);
    f    = (e / DIV - 1) / FR;
    if (f > 7) f = 7;
    mo = done && mv && !sample_ready;
    if (done && (!mv || sample_ready)) begin
      ml = fl[f];
      mr = fr[f];
      mv = 1'b1;
    end else if (mv && sample_ready) begin
      mv = 1'b0;
    end
    n = n + 1;
    #1;
  endtask

  task automatic assert_rst();
    @(negedge mclk);
    rst = 1'b1;
    #1;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge mclk);
    #1;
    rst = 1'b0;
    n   = 0;
    mv  = 1'b0;
    mo  = 1'b0;
    ml  = '0;
    mr  = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge mclk);
    #1;
    total++; if (adc_bclk !== 1'b0) $display("FAIL reset_bclk got=%b exp=0", adc_bclk); else passed++;
    total++; if (adc_lrck !== 1'b0) $display("FAIL reset_lrck got=%b exp=0", adc_lrck); else passed++;
    total++; if (sample_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", sample_valid); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", overrun); else passed++;
    total++; if (sample_l !== '0) $display("FAIL reset_l got=%h exp=0", sample_l); else passed++;
    total++; if (sample_r !== '0) $display("FAIL reset_r got=%h exp=0", sample_r); else passed++;
  endtask

  task automatic test_clocks();
    int bclk_rise1;
    int bclk_rise2;
    int lrck_rise;
    int lrck_fall;
    logic pb;
    logic pl;
    bclk_rise1 = -1; bclk_rise2 = -1; lrck_rise = -1; lrck_fall = -1;
    random_words();
    sample_ready = 1'b1;
    assert_rst();
    release_rst();
    pb = adc_bclk; pl = adc_lrck;
    for (int i = 0; i < 600; i++) begin
      step();
      total++;
      if (got_vec !== exp_vec()) $display("FAIL clocks n=%0d got=%h exp=%h", n, got_vec, exp_vec());
      else passed++;
      if (adc_bclk && !pb) begin
        if (bclk_rise1 < 0) bclk_rise1 = n;
        else if (bclk_rise2 < 0) bclk_rise2 = n;
      end
      if (adc_lrck && !pl && lrck_rise < 0) lrck_rise = n;
      if (!adc_lrck && pl && lrck_fall < 0) lrck_fall = n;
      pb = adc_bclk; pl = adc_lrck;
    end
    total++; if (bclk_rise1 != 4) $display("FAIL bclk_first_rise got=%0d exp=4", bclk_rise1); else passed++;
    total++; if (bclk_rise2 != 4 + DIV) $display("FAIL bclk_period got=%0d exp=%0d", bclk_rise2, 4 + DIV); else passed++;
    total++; if (lrck_rise != 256) $display("FAIL lrck_rise got=%0d exp=256", lrck_rise); else passed++;
    total++; if (lrck_fall != 512) $display("FAIL lrck_fall got=%0d exp=512", lrck_fall); else passed++;
  endtask

  task automatic test_pattern(input logic [SB-1:0] l, input logic [SB-1:0] r, input string name);
    int            first_v;
    int            vcount;
    logic [SB-1:0] lo;
    logic [SB-1:0] ro;
    first_v = -1; vcount = 0; lo = '0; ro = '0;
    random_words();
    fl[0] = l;
    fr[0] = r;
    sample_ready = 1'b1;
    assert_rst();
    release_rst();
    for (int i = 0; i < 1100; i++) begin
      step();
      total++;
      if (got_vec !== exp_vec()) $display("FAIL %s n=%0d got=%h exp=%h", name, n, got_vec, exp_vec());
      else passed++;
      if (sample_valid) begin
        if (first_v < 0) first_v = n;
        if (n < FIRST_VALID + PAIR_MCLK) vcount++;
      end
      if (n == FIRST_VALID) begin lo = sample_l; ro = sample_r; end
    end
    total++; if (first_v != FIRST_VALID) $display("FAIL %s_latency got=%0d exp=%0d", name, first_v, FIRST_VALID); else passed++;
    total++; if (vcount != 1) $display("FAIL %s_valid_width got=%0d exp=1", name, vcount); else passed++;
    total++; if (lo !== l) $display("FAIL %s_left got=%h exp=%h", name, lo, l); else passed++;
    total++; if (ro !== r) $display("FAIL %s_right got=%h exp=%h", name, ro, r); else passed++;
  endtask

  task automatic test_overrun();
    int ovr_cnt;
    int ovr_n;
    ovr_cnt = 0; ovr_n = -1;
    random_words();
    sample_ready = 1'b0;
    assert_rst();
    release_rst();
    for (int i = 0; i < 1100; i++) begin
      step();
      total++;
      if (got_vec !== exp_vec()) $display("FAIL overrun n=%0d got=%h exp=%h", n, got_vec, exp_vec());
      else passed++;
      if (overrun) begin ovr_cnt++; ovr_n = n; end
    end
    total++; if (ovr_cnt != 1) $display("FAIL overrun_count got=%0d exp=1", ovr_cnt); else passed++;
    total++; if (ovr_n != FIRST_VALID + PAIR_MCLK) $display("FAIL overrun_when got=%0d exp=%0d", ovr_n, FIRST_VALID + PAIR_MCLK); else passed++;
    total++; if (sample_valid !== 1'b1) $display("FAIL overrun_valid_held got=%b exp=1", sample_valid); else passed++;
    total++; if (sample_l !== fl[0]) $display("FAIL overrun_left_held got=%h exp=%h", sample_l, fl[0]); else passed++;
    total++; if (sample_r !== fr[0]) $display("FAIL overrun_right_held got=%h exp=%h", sample_r, fr[0]); else passed++;
    sample_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (got_vec !== exp_vec()) $display("FAIL overrun_drain n=%0d got=%h exp=%h", n, got_vec, exp_vec());
      else passed++;
    end
    total++; if (sample_valid !== 1'b0) $display("FAIL overrun_consumed got=%b exp=0", sample_valid); else passed++;
  endtask

  task automatic test_ready_on_completion();
    random_words();
    sample_ready = 1'b0;
    assert_rst();
    release_rst();
    for (int i = 0; i < FIRST_VALID + PAIR_MCLK - 1; i++) begin
      step();
      total++;
      if (got_vec !== exp_vec()) $display("FAIL ready_edge n=%0d got=%h exp=%h", n, got_vec, exp_vec());
      else passed++;
    end
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    total++; if (sample_valid !== 1'b1) $display("FAIL ready_edge_valid got=%b exp=1", sample_valid); else passed++;
    total++; if (sample_l !== fl[1]) $display("FAIL ready_edge_left got=%h exp=%h", sample_l, fl[1]); else passed++;
    total++; if (sample_r !== fr[1]) $display("FAIL ready_edge_right got=%h exp=%h", sample_r, fr[1]); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL ready_edge_overrun got=%b exp=0", overrun); else passed++;
    step();
    total++; if (overrun !== 1'b0) $display("FAIL ready_edge_overrun_late got=%b exp=0", overrun); else passed++;
    total++;
    if (got_vec !== exp_vec()) $display("FAIL ready_edge_after n=%0d got=%h exp=%h", n, got_vec, exp_vec());
    else passed++;
  endtask

  task automatic test_reset_midframe();
    int            first_v;
    logic [SB-1:0] lo;
    first_v = -1; lo = '0;
    random_words();
    sample_ready = 1'b0;
    assert_rst();
    release_rst();
    for (int i = 0; i < PAIR_MCLK + 40 * DIV; i++) begin
      step();
      total++;
      if (got_vec !== exp_vec()) $display("FAIL midreset_pre n=%0d got=%h exp=%h", n, got_vec, exp_vec());
      else passed++;
    end
    total++; if (sample_valid !== 1'b1) $display("FAIL midreset_held got=%b exp=1", sample_valid); else passed++;
    assert_rst();
    total++; if (got_vec !== '0) $display("FAIL midreset_zero got=%h exp=0", got_vec); else passed++;
    random_words();
    sample_ready = 1'b1;
    release_rst();
    for (int i = 0; i < 1000; i++) begin
      step();
      total++;
      if (got_vec !== exp_vec()) $display("FAIL midreset_post n=%0d got=%h exp=%h", n, got_vec, exp_vec());
      else passed++;
      if (sample_valid && first_v < 0) begin first_v = n; lo = sample_l; end
    end
    total++; if (first_v != FIRST_VALID) $display("FAIL midreset_first got=%0d exp=%0d", first_v, FIRST_VALID); else passed++;
    total++; if (lo !== fl[0]) $display("FAIL midreset_left got=%h exp=%h", lo, fl[0]); else passed++;
  endtask

  task automatic test_random();
    random_words();
    sample_ready = 1'b0;
    assert_rst();
    release_rst();
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) sample_ready = 1'($urandom);
      step();
      total++;
      if (got_vec !== exp_vec()) $display("FAIL random n=%0d got=%h exp=%h", n, got_vec, exp_vec());
      else passed++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    adc_sdata    = 1'b0;
    sample_ready = 1'b0;
    passed = 0; total = 0; n = 0;
    mv = 1'b0; mo = 1'b0; ml = '0; mr = '0;
    random_words();
    test_reset();
    test_clocks();
    test_pattern(24'hABCDEF, 24'h123456, "frame");
    test_pattern(24'h800000, 24'hFFFFFF, "negative");
    test_overrun();
    test_ready_on_completion();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
